sim_frame_sequencer: RTL and testbench

// Top-level controller for the SPH simulator core. Issues restart_sim and new_frame, waits for frame_complete,
// and paces simulation frames to display vsync (1 sim frame per FRAME_DIV vsyncs).

---
 rtl/sim_frame_sequencer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_sim_frame_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sim_frame_sequencer
// Description : Top-level controller for the SPH simulator core. Restarts the
//               particle simulation, paces simulation frames to display vsync
//               (one sim frame per FRAME_DIV vsyncs), holds the simulation
//               configuration stable for a whole frame, detects hung frames
//               with a watchdog and supports pause / single-step for debug.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_in              in   1             system clock
//   rst_in_n            in   1             asynchronous active-low reset
//   start_req           in   1             pulse: (re)initialise, top priority
//   pause               in   1             level: no new frames started
//   step                in   1             pulse: run one frame while paused
//   vsync_in            in   1             one-cycle pulse per display frame
//   frame_complete      in   1             pulse from simulator: frame done
//   particle_count_in   in   COUNTER_SIZE  requested particle count
//   grav_in             in   16            gravity (fp16)
//   pressure_in         in   16            pressure constant (fp16)
//   density_in          in   16            target density (fp16)
//   restart_sim         out  1             high for each RESTART cycle
//   new_frame           out  1             one-cycle pulse, first RUN cycle
//   particle_count_out  out  COUNTER_SIZE  count latched at RESTART
//   grav_out            out  16            gravity latched at frame start
//   pressure_out        out  16            pressure latched at frame start
//   density_out         out  16            density latched at frame start
//   frame_count         out  COUNTER_SIZE  completed frames, wraps
//   overrun             out  1             one-cycle pulse: vsync hit a RUN
//   fault               out  1             level: watchdog expired
//   state_out           out  3             encoded state for debug LEDs
// ============================================================================
module sim_frame_sequencer #(
  parameter int COUNTER_SIZE   = 16,
  parameter int FRAME_DIV      = 1,
  parameter int TIMEOUT_CYCLES = 4_000_000,
  parameter int RESET_SLACK    = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_in_n,
  input  logic                    start_req,
  input  logic                    pause,
  input  logic                    step,
  input  logic                    vsync_in,
  input  logic                    frame_complete,
  input  logic [COUNTER_SIZE-1:0] particle_count_in,
  input  logic [15:0]             grav_in,
  input  logic [15:0]             pressure_in,
  input  logic [15:0]             density_in,
  output logic                    restart_sim,
  output logic                    new_frame,
  output logic [COUNTER_SIZE-1:0] particle_count_out,
  output logic [15:0]             grav_out,
  output logic [15:0]             pressure_out,
  output logic [15:0]             density_out,
  output logic [COUNTER_SIZE-1:0] frame_count,
  output logic                    overrun,
  output logic                    fault,
  output logic [2:0]              state_out
);

  // --------------------------------------------------------------------------
  // Counter widths and constants
  // --------------------------------------------------------------------------
  // tick counter only ever needs to hold FRAME_DIV-1
  localparam int TICK_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  // watchdog only ever needs to hold TIMEOUT_CYCLES-1
  localparam int WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // settle counter holds particle_count_in + RESET_SLACK without overflow
  localparam int WAIT_W = $clog2((2 ** COUNTER_SIZE) + RESET_SLACK);

  localparam logic [TICK_W-1:0] C_TICK_LAST = TICK_W'(FRAME_DIV - 1);
  localparam logic [WD_W-1:0]   C_WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] C_SLACK     = WAIT_W'(RESET_SLACK);
  localparam logic [WAIT_W-1:0] C_WAIT_ONE  = WAIT_W'(1);

  localparam logic [2:0] C_ST_BOOT      = 3'd0;
  localparam logic [2:0] C_ST_RESTART   = 3'd1;
  localparam logic [2:0] C_ST_SETTLE    = 3'd2;
  localparam logic [2:0] C_ST_WAIT_TICK = 3'd3;
  localparam logic [2:0] C_ST_RUN       = 3'd4;
  localparam logic [2:0] C_ST_FAULT     = 3'd5;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]              state_q,     state_d;
  logic [WAIT_W-1:0]       wait_cnt_q,  wait_cnt_d;
  logic [TICK_W-1:0]       tick_cnt_q,  tick_cnt_d;
  logic [WD_W-1:0]         wd_cnt_q,    wd_cnt_d;
  logic [COUNTER_SIZE-1:0] frame_cnt_q, frame_cnt_d;
  logic [COUNTER_SIZE-1:0] pcount_q,    pcount_d;
  logic [15:0]             grav_q,      grav_d;
  logic [15:0]             pressure_q,  pressure_d;
  logic [15:0]             density_q,   density_d;
  logic                    new_frame_q, new_frame_d;
  logic                    overrun_q,   overrun_d;

  // --------------------------------------------------------------------------
  // Event decode
  // --------------------------------------------------------------------------
  logic w_fire;      // a new simulation frame starts at the coming edge
  logic w_complete;  // a valid (non-stale) frame_complete in RUN
  logic w_expire;    // watchdog reached its last allowed RUN cycle
  logic w_settled;   // the settle countdown reaches zero at the coming edge

  // Paused: only step may start a frame; unpaused: the FRAME_DIV-th vsync.
  assign w_fire = (state_q == C_ST_WAIT_TICK) &&
                  ((!pause && vsync_in && (tick_cnt_q == C_TICK_LAST)) ||
                   (pause && step));

  // frame_complete seen while new_frame is still high belongs to the previous
  // frame and is discarded.
  assign w_complete = (state_q == C_ST_RUN) && frame_complete && !new_frame_q;

  assign w_expire  = (state_q == C_ST_RUN) && (wd_cnt_q == C_WD_LAST);

  // Loaded with N, the countdown leaves SETTLE after exactly N cycles
  // (immediately when N is zero).
  assign w_settled = (state_q == C_ST_SETTLE) && (wait_cnt_q <= C_WAIT_ONE);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q <= C_ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (start_req) begin
      // start_req outranks every other event, in every state
      state_d = C_ST_RESTART;
    end else begin
      case (state_q)
        C_ST_BOOT:      state_d = C_ST_RESTART;
        C_ST_RESTART:   state_d = C_ST_SETTLE;
        C_ST_SETTLE: begin
          if (w_settled) state_d = C_ST_WAIT_TICK;
        end
        C_ST_WAIT_TICK: begin
          if (w_fire) state_d = C_ST_RUN;
        end
        C_ST_RUN: begin
          // a completion on the last watchdog cycle still counts as success
          if (w_complete)    state_d = C_ST_WAIT_TICK;
          else if (w_expire) state_d = C_ST_FAULT;
        end
        C_ST_FAULT:     state_d = C_ST_FAULT;
        default:        state_d = C_ST_BOOT;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    tick_cnt_d  = tick_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    frame_cnt_d = frame_cnt_q;
    pcount_d    = pcount_q;
    grav_d      = grav_q;
    pressure_d  = pressure_q;
    density_d   = density_q;
    new_frame_d = 1'b0;
    overrun_d   = 1'b0;

    if (start_req) begin
      wait_cnt_d  = '0;
      tick_cnt_d  = '0;
      wd_cnt_d    = '0;
      frame_cnt_d = '0;
    end else begin
      case (state_q)
        C_ST_RESTART: begin
          pcount_d   = particle_count_in;
          wait_cnt_d = WAIT_W'(particle_count_in) + C_SLACK;
        end
        C_ST_SETTLE: begin
          if (w_settled) begin
            wait_cnt_d  = '0;
            tick_cnt_d  = '0;
            frame_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q - C_WAIT_ONE;
          end
        end
        C_ST_WAIT_TICK: begin
          if (w_fire) begin
            // config is frozen here and held for the whole frame
            new_frame_d = 1'b1;
            grav_d      = grav_in;
            pressure_d  = pressure_in;
            density_d   = density_in;
            tick_cnt_d  = '0;
            wd_cnt_d    = '0;
          end else if (vsync_in && (tick_cnt_q != C_TICK_LAST)) begin
            // saturating: while paused, ticks pile up at FRAME_DIV-1
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
        C_ST_RUN: begin
          wd_cnt_d  = wd_cnt_q + WD_W'(1);
          // a vsync during RUN is dropped, not carried into tick_cnt
          overrun_d = vsync_in;
          if (w_complete) begin
            frame_cnt_d = frame_cnt_q + COUNTER_SIZE'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      wait_cnt_q  <= '0;
      tick_cnt_q  <= '0;
      wd_cnt_q    <= '0;
      frame_cnt_q <= '0;
      pcount_q    <= '0;
      grav_q      <= '0;
      pressure_q  <= '0;
      density_q   <= '0;
      new_frame_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      pcount_q    <= pcount_d;
      grav_q      <= grav_d;
      pressure_q  <= pressure_d;
      density_q   <= density_d;
      new_frame_q <= new_frame_d;
      overrun_q   <= overrun_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  // restart_sim and fault decode straight from the state register, so reset
  // drives them low asynchronously and restart_sim can never coincide with
  // new_frame (which is only ever high in RUN).
  always_comb begin
    restart_sim        = (state_q == C_ST_RESTART);
    fault              = (state_q == C_ST_FAULT);
    state_out          = state_q;
    new_frame          = new_frame_q;
    overrun            = overrun_q;
    frame_count        = frame_cnt_q;
    particle_count_out = pcount_q;
    grav_out           = grav_q;
    pressure_out       = pressure_q;
    density_out        = density_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_sim_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sim_frame_sequencer
// Description : Self-checking bench for sim_frame_sequencer: a table of
//               single-cycle vectors, directed multi-cycle sequences (boot,
//               pacing, pause/step, overrun, watchdog, restart, async reset)
//               and a randomized run against an event-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sim_frame_sequencer;

  localparam int CS   = 16;
  localparam int FDIV = 2;
  localparam int TMO  = 1000;
  localparam int SLK  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_req, pause, step, vsync, frame_complete;
  logic [CS-1:0] pcount_in;
  logic [15:0]   grav_in, pressure_in, density_in;
  logic          restart_sim, new_frame, overrun, fault;
  logic [CS-1:0] pcount_out, frame_count;
  logic [15:0]   grav_out, pressure_out, density_out;
  logic [2:0]    state_out;

  sim_frame_sequencer #(
    .COUNTER_SIZE  (CS),
    .FRAME_DIV     (FDIV),
    .TIMEOUT_CYCLES(TMO),
    .RESET_SLACK   (SLK)
  ) dut (
    .clk_in            (clk),
    .rst_in_n          (rst_n),
    .start_req         (start_req),
    .pause             (pause),
    .step              (step),
    .vsync_in          (vsync),
    .frame_complete    (frame_complete),
    .particle_count_in (pcount_in),
    .grav_in           (grav_in),
    .pressure_in       (pressure_in),
    .density_in        (density_in),
    .restart_sim       (restart_sim),
    .new_frame         (new_frame),
    .particle_count_out(pcount_out),
    .grav_out          (grav_out),
    .pressure_out      (pressure_out),
    .density_out       (density_out),
    .frame_count       (frame_count),
    .overrun           (overrun),
    .fault             (fault),
    .state_out         (state_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nf_cnt = 0;
  int ov_cnt = 0;

  typedef struct {
    logic       vs, fc, pa, st, sr;
    logic [2:0] e_state;
    logic       e_nf, e_ov, e_rs;
    logic [15:0] e_fcnt;
  } vec_t;

  vec_t tbl [0:19];

  function automatic vec_t mk(input logic vs, input logic fc, input logic pa,
                              input logic st, input logic sr, input logic [2:0] es,
                              input logic nf, input logic ov, input logic rs,
                              input logic [15:0] fcnt);
    vec_t v;
    v.vs = vs; v.fc = fc; v.pa = pa; v.st = st; v.sr = sr;
    v.e_state = es; v.e_nf = nf; v.e_ov = ov; v.e_rs = rs; v.e_fcnt = fcnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // advance one cycle; outputs are observed on the falling edge
  task automatic tick();
    @(negedge clk);
    if (new_frame === 1'b1) nf_cnt++;
    if (overrun === 1'b1) ov_cnt++;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (state_out !== s && n < budget) begin
      tick();
      n++;
    end
    chk("wait_state", {29'd0, state_out}, {29'd0, s});
  endtask

  // two vsyncs from a cleared tick count start a frame; new_frame is high
  // when this returns
  task automatic fire_frame();
    vsync = 1'b1; tick(); vsync = 1'b0;
    tick();
    vsync = 1'b1; tick(); vsync = 1'b0;
  endtask

  task automatic pulse_fc();
    frame_complete = 1'b1; tick(); frame_complete = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin : main
    int n;
    int nf0, ov0;
    // reference model state for the random phase
    bit m_run;
    int m_ticks, m_frames, m_age;
    logic [15:0] m_grav;
    logic exp_nf, exp_ov, nx_nf, nx_ov;

    rst_n = 1'b0; start_req = 1'b0; pause = 1'b0; step = 1'b0;
    vsync = 1'b0; frame_complete = 1'b0; pcount_in = 16'd100;
    grav_in = 16'h0; pressure_in = 16'h0; density_in = 16'h0;

    // ---------------- reset and boot ----------------
    repeat (3) tick();
    chk("rst_restart_sim", restart_sim, 0);
    chk("rst_new_frame", new_frame, 0);
    chk("rst_state", state_out, 0);
    chk("rst_fault", fault, 0);
    chk("rst_pcount", pcount_out, 0);
    chk("rst_frame_count", frame_count, 0);
    rst_n = 1'b1;
    chk("boot_state", state_out, 0);
    tick();
    chk("boot_restart_sim_cycle2", restart_sim, 1);
    tick();
    chk("restart_one_cycle", restart_sim, 0);
    chk("settle_state", state_out, 2);
    chk("pcount_latched", pcount_out, 100);
    pcount_in = 16'd2;
    n = 0;
    while (state_out === 3'd2 && n < 300) begin
      n++;
      tick();
    end
    chk("settle_cycles", n, 108);
    chk("wait_tick_after_settle", state_out, 3);
    chk("pcount_not_retaken", pcount_out, 100);

    // ---------------- table-driven single-cycle vectors ----------------
    //            vs fc pa st sr  state nf ov rs fcnt
    tbl[0]  = mk(1, 0, 0, 0, 0, 3'd3, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 3'd3, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 3'd4, 1, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 0, 3'd4, 0, 0, 0, 0);  // stale completion
    tbl[4]  = mk(1, 0, 0, 0, 0, 3'd4, 0, 1, 0, 0);  // overrun
    tbl[5]  = mk(0, 0, 0, 0, 0, 3'd4, 0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 0, 0, 0, 3'd3, 0, 0, 0, 1);
    tbl[7]  = mk(1, 0, 0, 0, 0, 3'd3, 0, 0, 0, 1);  // dropped tick not carried
    tbl[8]  = mk(1, 0, 1, 0, 0, 3'd3, 0, 0, 0, 1);  // paused
    tbl[9]  = mk(1, 0, 1, 0, 0, 3'd3, 0, 0, 0, 1);
    tbl[10] = mk(0, 0, 1, 1, 0, 3'd4, 1, 0, 0, 1);  // step
    tbl[11] = mk(0, 1, 1, 0, 0, 3'd4, 0, 0, 0, 1);
    tbl[12] = mk(0, 1, 1, 0, 0, 3'd3, 0, 0, 0, 2);
    tbl[13] = mk(0, 0, 0, 1, 0, 3'd3, 0, 0, 0, 2);  // step ignored unpaused
    tbl[14] = mk(1, 0, 0, 0, 0, 3'd3, 0, 0, 0, 2);
    tbl[15] = mk(1, 0, 0, 0, 0, 3'd4, 1, 0, 0, 2);
    tbl[16] = mk(0, 0, 0, 0, 0, 3'd4, 0, 0, 0, 2);
    tbl[17] = mk(1, 1, 0, 0, 1, 3'd1, 0, 0, 1, 0);  // start beats fc+vsync
    tbl[18] = mk(0, 0, 0, 0, 1, 3'd1, 0, 0, 1, 0);  // re-pulse restart
    tbl[19] = mk(0, 0, 0, 0, 0, 3'd2, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      vsync = tbl[i].vs; frame_complete = tbl[i].fc; pause = tbl[i].pa;
      step = tbl[i].st; start_req = tbl[i].sr;
      tick();
      chk($sformatf("vec%0d_state", i), state_out, tbl[i].e_state);
      chk($sformatf("vec%0d_new_frame", i), new_frame, tbl[i].e_nf);
      chk($sformatf("vec%0d_overrun", i), overrun, tbl[i].e_ov);
      chk($sformatf("vec%0d_restart_sim", i), restart_sim, tbl[i].e_rs);
      chk($sformatf("vec%0d_frame_count", i), frame_count, tbl[i].e_fcnt);
    end
    vsync = 0; frame_complete = 0; pause = 0; step = 0; start_req = 0;
    wait_state(3'd3, 50);
    chk("pcount_second_restart", pcount_out, 2);

    // ---------------- pacing with FRAME_DIV=2, config latching ----------------
    grav_in = 16'h1111; pressure_in = 16'h2222; density_in = 16'h3333;
    nf0 = nf_cnt; ov0 = ov_cnt;
    fire_frame();
    chk("pace_nf1", new_frame, 1);
    chk("pace_grav1", grav_out, 16'h1111);
    chk("pace_pressure1", pressure_out, 16'h2222);
    chk("pace_density1", density_out, 16'h3333);
    grav_in = 16'hAAAA;
    repeat (49) tick();
    chk("grav_held_during_run", grav_out, 16'h1111);
    chk("restart_never_in_run", restart_sim, 0);
    pulse_fc();
    chk("pace_back_to_wait", state_out, 3);
    chk("pace_fcount1", frame_count, 1);
    fire_frame();
    chk("pace_grav2", grav_out, 16'hAAAA);
    repeat (49) tick();
    pulse_fc();
    chk("pace_nf_pulses", nf_cnt - nf0, 2);
    chk("pace_fcount2", frame_count, 2);
    chk("pace_no_overrun", ov_cnt - ov0, 0);

    // ---------------- pause then step ----------------
    pause = 1'b1; nf0 = nf_cnt;
    repeat (3) begin
      vsync = 1'b1; tick(); vsync = 1'b0; tick();
    end
    chk("pause_no_frames", nf_cnt - nf0, 0);
    chk("pause_state", state_out, 3);
    step = 1'b1; tick(); step = 1'b0;
    chk("step_new_frame", new_frame, 1);
    repeat (5) tick();
    chk("step_exactly_one", nf_cnt - nf0, 1);
    pulse_fc();
    chk("step_fcount", frame_count, 3);
    pause = 1'b0;

    // ---------------- overrun ----------------
    nf0 = nf_cnt; ov0 = ov_cnt;
    fire_frame();
    tick();
    vsync = 1'b1; tick(); vsync = 1'b0;
    chk("overrun_pulse", overrun, 1);
    tick();
    chk("overrun_one_cycle", overrun, 0);
    repeat (3) tick();
    chk("overrun_no_extra_nf", nf_cnt - nf0, 1);
    chk("overrun_count", ov_cnt - ov0, 1);
    pulse_fc();
    chk("overrun_fcount", frame_count, 4);
    vsync = 1'b1; tick(); vsync = 1'b0;
    chk("dropped_tick_first_vsync", new_frame, 0);
    vsync = 1'b1; tick(); vsync = 1'b0;
    chk("dropped_tick_second_vsync", new_frame, 1);
    tick();
    pulse_fc();
    chk("fcount5", frame_count, 5);

    // ---------------- watchdog ----------------
    fire_frame();
    repeat (TMO - 1) tick();
    chk("wd_no_fault_at_999", fault, 0);
    chk("wd_still_run", state_out, 4);
    tick();
    chk("wd_fault_at_1000", fault, 1);
    chk("wd_fault_state", state_out, 5);
    nf0 = nf_cnt; ov0 = ov_cnt;
    vsync = 1'b1; tick(); vsync = 1'b0;
    pulse_fc();
    pause = 1'b1; step = 1'b1; tick(); step = 1'b0; pause = 1'b0;
    repeat (3) tick();
    chk("fault_held", fault, 1);
    chk("fault_idle_nf", nf_cnt - nf0, 0);
    chk("fault_idle_ov", ov_cnt - ov0, 0);
    chk("fault_idle_restart", restart_sim, 0);

    // ---------------- restart out of FAULT ----------------
    pcount_in = 16'd4;
    start_req = 1'b1; tick(); start_req = 1'b0;
    chk("fault_cleared", fault, 0);
    chk("fault_restart_pulse", restart_sim, 1);
    chk("fault_restart_fcount", frame_count, 0);
    tick();
    chk("fault_restart_done", restart_sim, 0);
    wait_state(3'd3, 50);
    chk("pcount_after_fault", pcount_out, 4);

    // ---------------- asynchronous reset mid-RUN ----------------
    grav_in = 16'h5A5A;
    fire_frame();
    chk("pre_async_nf", new_frame, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_nf", new_frame, 0);
    chk("async_state", state_out, 0);
    chk("async_grav", grav_out, 0);
    chk("async_pcount", pcount_out, 0);
    chk("async_restart", restart_sim, 0);
    repeat (2) tick();
    pcount_in = 16'd0;
    rst_n = 1'b1;
    chk("async_boot", state_out, 0);
    tick();
    chk("async_reboot_restart", restart_sim, 1);
    wait_state(3'd3, 50);

    // ---------------- randomized run vs reference model ----------------
    m_run = 0; m_ticks = 0; m_frames = 0; m_age = 0; m_grav = 16'h0;
    exp_nf = 0; exp_ov = 0;
    for (int i = 0; i < 3000; i++) begin
      chk("rnd_new_frame", new_frame, exp_nf);
      chk("rnd_overrun", overrun, exp_ov);
      chk("rnd_frame_count", frame_count, m_frames);
      chk("rnd_grav", grav_out, m_grav);
      chk("rnd_restart", restart_sim, 0);

      vsync = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) pause = ~pause;
      step = ($urandom_range(0, 9) == 0);
      if (m_run) frame_complete = (m_age >= 400) || ($urandom_range(0, 5) == 0);
      else       frame_complete = ($urandom_range(0, 19) == 0);
      grav_in = 16'($urandom);

      if (m_run) begin
        nx_ov = vsync;
        nx_nf = 0;
        if (frame_complete && !exp_nf) begin
          m_run = 0;
          m_frames = (m_frames + 1) % 65536;
        end
        m_age++;
      end else begin
        nx_ov = 0;
        if ((pause && step) || (!pause && vsync && m_ticks == FDIV - 1)) begin
          m_run = 1; nx_nf = 1; m_grav = grav_in; m_ticks = 0; m_age = 0;
        end else begin
          nx_nf = 0;
          if (vsync && m_ticks < FDIV - 1) m_ticks++;
        end
      end
      exp_nf = nx_nf; exp_ov = nx_ov;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
